fifo_flagged: RTL and testbench

Parametrised successor to the team's plain push/pop FIFO for the interleaver datapath. Same show-ahead storage model, with added registered occupancy count, full/empty and programmable almost-full/almost-empty flags, push/pop guarding, sticky overflow/underflow error flags and a synchronous flush. Drop-in buffer for interleaver/deinterleaver branches and any producer/consumer stage needing back-pressure.

---
 rtl/fifo_flagged_pkg.sv | 29 ++
 rtl/fifo_flagged_if.sv | 30 +++
 rtl/fifo_flagged_ram.sv | 26 ++
 rtl/fifo_flagged.sv | 129 ++++++++++++
 tb/tb_fifo_flagged.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fifo_flagged_pkg.sv
// Shared helpers for fifo_flagged: width derivation and pointer wrap arithmetic.
package fifo_flagged_pkg;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int r;
    v = value - 32'd1;
    r = 0;
    while (v > 32'd0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int unsigned depth);
    return clog2(depth + 32'd1);
  endfunction

  function automatic int addr_width(input int unsigned depth);
    return (depth < 32'd2) ? 32'sd1 : clog2(depth);
  endfunction

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Handshake, data and status bundle between a producer/consumer and fifo_flagged.
interface fifo_flagged_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 9
);
  logic             push;
  logic             pop;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] max_level;

  modport master (
    output push, pop, flush, clear_err, din,
    input  dout, count, empty, full, almost_full, almost_empty, overflow, underflow, max_level
  );

  modport slave (
    input  push, pop, flush, clear_err, din,
    output dout, count, empty, full, almost_full, almost_empty, overflow, underflow, max_level
  );
endinterface

// File: rtl/fifo_flagged_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous (show-ahead) read port.
module fifo_flagged_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flagged.sv
// Show-ahead FIFO with registered count/flags, sticky errors and flush.
// Optional high-water mark on max_level when FIFO_HWM_EN is defined.
module fifo_flagged
  import fifo_flagged_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  fifo_flagged_if.slave bus
);

  localparam int CNT_W  = cnt_width(DEPTH);
  localparam int ADDR_W = addr_width(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [ADDR_W-1:0] waddr_r, raddr_r;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic              empty_r, full_r, af_r, ae_r, ovf_r, unf_r;
  logic              pop_ok_s, wr_s, rd_s, ovf_ev_s, unf_ev_s;
  logic [WIDTH-1:0]  dout_s;

  // Qualified operations, error events and next-state occupancy; flush masks everything.
  always_comb begin
    pop_ok_s    = bus.pop & ~empty_r;
    wr_s        = bus.push & (~full_r | pop_ok_s) & ~bus.flush;
    rd_s        = pop_ok_s & ~bus.flush;
    ovf_ev_s    = bus.push & full_r & ~pop_ok_s & ~bus.flush;
    unf_ev_s    = bus.pop & empty_r & ~bus.flush;
    count_nxt_s = count_r;
    if (bus.flush) begin
      count_nxt_s = ZERO_C;
    end else if (wr_s & ~rd_s) begin
      count_nxt_s = count_r + ONE_C;
    end else if (rd_s & ~wr_s) begin
      count_nxt_s = count_r - ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, count and flags all move on the same edge from next-state count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr_r <= {ADDR_W{1'b0}};
      raddr_r <= {ADDR_W{1'b0}};
      count_r <= ZERO_C;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      af_r    <= (AF_C == ZERO_C);
      ae_r    <= 1'b1;
    end else begin
      if (bus.flush) begin
        waddr_r <= {ADDR_W{1'b0}};
        raddr_r <= {ADDR_W{1'b0}};
      end else begin
        if (wr_s) waddr_r <= ADDR_W'(wrap_inc(32'(waddr_r), 32'(DEPTH)));
        if (rd_s) raddr_r <= ADDR_W'(wrap_inc(32'(raddr_r), 32'(DEPTH)));
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == ZERO_C);
      full_r  <= (count_nxt_s == DEPTH_C);
      af_r    <= (count_nxt_s >= AF_C);
      ae_r    <= (count_nxt_s <= AE_C);
    end
  end

  // Sticky errors: a same-cycle error event beats clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (ovf_ev_s) ovf_r <= 1'b1;
      else if (bus.clear_err) ovf_r <= 1'b0;
      if (unf_ev_s) unf_r <= 1'b1;
      else if (bus.clear_err) unf_r <= 1'b0;
    end
  end

`ifdef FIFO_HWM_EN
  logic [CNT_W-1:0] max_r;

  // High-water mark; clear_err restarts tracking from the occupancy being registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_r <= ZERO_C;
    end else if (bus.clear_err) begin
      max_r <= count_nxt_s;
    end else if (count_nxt_s > max_r) begin
      max_r <= count_nxt_s;
    end
  end

  assign bus.max_level = max_r;
`else
  assign bus.max_level = ZERO_C;
`endif

  fifo_flagged_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_s),
    .waddr(waddr_r),
    .wdata(bus.din),
    .raddr(raddr_r),
    .rdata(dout_s)
  );

  assign bus.dout         = dout_s;
  assign bus.count        = count_r;
  assign bus.empty        = empty_r;
  assign bus.full         = full_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_fifo_flagged.sv
// Self-checking bench for fifo_flagged (DEPTH=8): vector table plus scoreboard-driven sequences.
module tb_fifo_flagged;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CNT_W = 4;

  logic clk;
  logic reset_n;

  fifo_flagged_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fifo_flagged #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic       flush;
    logic       clr;
    logic [7:0] din;
    int         exp_cnt;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t       vecs[19];
  logic [7:0] q[$];
  int         checks = 0;
  int         errors = 0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  int         m_max = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("count", int'(bus.count), q.size());
    chk("empty", int'(bus.empty), int'(q.size() == 0));
    chk("full", int'(bus.full), int'(q.size() == DEPTH));
    chk("almost_full", int'(bus.almost_full), int'(q.size() >= AF));
    chk("almost_empty", int'(bus.almost_empty), int'(q.size() <= AE));
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("underflow", int'(bus.underflow), int'(m_unf));
    chk("max_level", int'(bus.max_level), m_max);
  endtask

  // One clock: drive, check head on accepted pops, update reference model, check after the edge.
  task automatic step(input logic p, input logic po, input logic fl, input logic ce, input logic [7:0] d);
    bit full_m, empty_m, pop_ok, wr, ovf_ev, unf_ev;
    bus.push = p; bus.pop = po; bus.flush = fl; bus.clear_err = ce; bus.din = d;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    pop_ok  = po && !empty_m;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    #2;
    if (pop_ok && !fl) chk("dout_head", int'(bus.dout), int'(q[0]));
    if (fl) begin
      q.delete();
    end else begin
      wr     = p && (!full_m || pop_ok);
      ovf_ev = p && full_m && !pop_ok;
      unf_ev = po && empty_m;
      if (pop_ok) void'(q.pop_front());
      if (wr) q.push_back(d);
    end
    if (ovf_ev) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
    if (unf_ev) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
`ifdef FIFO_HWM_EN
    if (ce) m_max = q.size();
    else if (q.size() > m_max) m_max = q.size();
`endif
    @(posedge clk);
    #1;
    chk_state();
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clear_err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 1), i + 1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 8, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) vecs[9 + i] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 7 - i, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};

    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clear_err = 1'b0; bus.din = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_state();
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to full, overflow attempt, drain, underflow attempt, clear.
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, vecs[i].din);
      chk("vec_count", int'(bus.count), vecs[i].exp_cnt);
      chk("vec_overflow", int'(bus.overflow), int'(vecs[i].exp_ovf));
      chk("vec_underflow", int'(bus.underflow), int'(vecs[i].exp_unf));
      if (i == 8) chk("dout_after_ovf", int'(bus.dout), 32'h01);
    end

    // Push+pop on a full FIFO.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h11 + i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    chk("full_pp_next_head", int'(bus.dout), 32'h12);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("aa_emerges", int'(bus.dout), 32'hAA);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end

    // Random interleave across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50), 1'b0, 1'b0, 8'($urandom));
    end
    for (int i = 0; i < DEPTH && q.size() > 0; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Flush at count 5 with a pending overflow flag.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h30 + i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // High-water mark and clear_err reload.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h60);

    // Asynchronous reset at count 3, away from any clock edge.
    #1;
    reset_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_max = 0;
    chk_state();
    @(negedge clk);
    reset_n = 1'b1;

    // Push and pop together on empty: no bypass, underflow flagged, data written.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    chk("no_bypass_written", int'(bus.dout), 32'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
